// File: rtl/mcs4_cycle_sequencer.sv
// MCS-4 instruction-cycle sequencer: 8-phase subcycle stepping, SYNC,
// OPR/OPA and second-word latching, two-word/FIN sequencing, halt control
// and datapath strobes.

package mcs4;

  localparam int unsigned Char_width = 4;
  localparam int unsigned Cyc_width  = 3;

  // Subcycles of one instruction cycle, in bus order
  typedef enum logic [Cyc_width-1:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } instr_cyc_t;

  // Which word of the current instruction is on the bus
  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    FIND   = 2'd2
  } word_state_t;

  // OPR encodings that matter to the sequencer
  localparam logic [Char_width-1:0] JCN_OPR     = 4'h1;
  localparam logic [Char_width-1:0] FIM_SRC_OPR = 4'h2;
  localparam logic [Char_width-1:0] FIN_JIN_OPR = 4'h3;
  localparam logic [Char_width-1:0] JUN_OPR     = 4'h4;
  localparam logic [Char_width-1:0] JMS_OPR     = 4'h5;
  localparam logic [Char_width-1:0] ISZ_OPR     = 4'h7;
  localparam logic [Char_width-1:0] IORAM_OPR   = 4'hE;

endpackage

module mcs4_cycle_sequencer
  import mcs4::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic [Char_width-1:0] bus_in,
  output instr_cyc_t            cycle,
  output logic                  sync,
  output logic [Char_width-1:0] opr,
  output logic [Char_width-1:0] opa,
  output logic [Char_width-1:0] arg_hi,
  output logic [Char_width-1:0] arg_lo,
  output logic                  word2,
  output logic                  fin_ind,
  output logic                  pc_inc,
  output logic                  exec,
  output logic                  cm_rom,
  output logic                  cm_ram,
  output logic                  halted
);

  word_state_t           word_q;
  word_state_t           word_nxt;
  instr_cyc_t            cycle_nxt;
  logic [Char_width-1:0] opr_nxt;
  logic [Char_width-1:0] opa_nxt;
  logic [Char_width-1:0] arg_hi_nxt;
  logic [Char_width-1:0] arg_lo_nxt;
  logic                  halted_nxt;

  logic                  two_word;
  logic                  fin_op;
  logic                  live;
  logic                  exec_phase;
  logic                  instr_done;
  logic                  io_sel;

  // Classify the latched first word
  always_comb begin
    two_word = 1'b0;
    fin_op   = 1'b0;
    case (opr)
      JCN_OPR, JUN_OPR, JMS_OPR, ISZ_OPR: two_word = 1'b1;
      FIM_SRC_OPR:                        two_word = ~opa[0];
      FIN_JIN_OPR:                        fin_op   = ~opa[0];
      default: begin
        two_word = 1'b0;
        fin_op   = 1'b0;
      end
    endcase
  end

  // Next-state logic: subcycle advance, nibble latching, word sequencing, halt
  always_comb begin
    cycle_nxt  = cycle;
    word_nxt   = word_q;
    opr_nxt    = opr;
    opa_nxt    = opa;
    arg_hi_nxt = arg_hi;
    arg_lo_nxt = arg_lo;
    halted_nxt = halted;

    if (halted) begin
      // Stay parked at A1 until the request drops; step is ignored
      if (!halt_req) begin
        halted_nxt = 1'b0;
      end
    end else if (step) begin
      case (cycle)
        M1: begin
          if (word_q == FIRST) opr_nxt    = bus_in;
          else                 arg_hi_nxt = bus_in;
        end
        M2: begin
          if (word_q == FIRST) opa_nxt    = bus_in;
          else                 arg_lo_nxt = bus_in;
        end
        X3: begin
          if ((word_q == FIRST) && two_word)    word_nxt = SECOND;
          else if ((word_q == FIRST) && fin_op) word_nxt = FIND;
          else                                  word_nxt = FIRST;
          // Halt only at an instruction boundary
          if ((word_nxt == FIRST) && halt_req) begin
            halted_nxt = 1'b1;
          end
        end
        default: begin
          word_nxt = word_q;
        end
      endcase

      if (cycle == X3) cycle_nxt = A1;
      else             cycle_nxt = instr_cyc_t'(Cyc_width'(cycle) + Cyc_width'(1));
    end
  end

  // State and latch registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle  <= A1;
      word_q <= FIRST;
      opr    <= '0;
      opa    <= '0;
      arg_hi <= '0;
      arg_lo <= '0;
      halted <= 1'b0;
    end else begin
      cycle  <= cycle_nxt;
      word_q <= word_nxt;
      opr    <= opr_nxt;
      opa    <= opa_nxt;
      arg_hi <= arg_hi_nxt;
      arg_lo <= arg_lo_nxt;
      halted <= halted_nxt;
    end
  end

  // Datapath strobes; suppressed during reset and while halted
  always_comb begin
    live       = ~rst & ~halted;
    exec_phase = (cycle == X1) | (cycle == X2) | (cycle == X3);
    instr_done = ((word_q == FIRST) & ~two_word & ~fin_op)
               | (word_q == SECOND)
               | (word_q == FIND);

    word2   = (word_q == SECOND);
    fin_ind = (word_q == FIND);

    sync   = live & (cycle == X3);
    // FIND fetch addresses through register pair 0, so the PC holds
    pc_inc = live & step & (cycle == M2) & (word_q != FIND);
    exec   = live & exec_phase & instr_done;

    // I/O-RAM group or SRC selects the ROM/RAM chips at X2
    io_sel = exec & ((opr == IORAM_OPR) | ((opr == FIM_SRC_OPR) & opa[0]));
    cm_rom = live & ((cycle == A3) | ((cycle == X2) & io_sel));
    cm_ram = live & (cycle == X2) & io_sel;
  end

endmodule

// File: tb/tb_mcs4_cycle_sequencer.sv
// Scoreboard bench for mcs4_cycle_sequencer: directed instruction streams
// followed by randomized step/halt/reset/bus traffic, checked every clock.

module tb_mcs4_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b1;
  logic       halt_req = 1'b0;
  logic [3:0] bus_in = 4'h0;

  logic [2:0] cycle;
  logic       sync;
  logic [3:0] opr, opa, arg_hi, arg_lo;
  logic       word2, fin_ind, pc_inc, exec, cm_rom, cm_ram, halted;

  always #5 clk = ~clk;

  mcs4_cycle_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .halt_req (halt_req),
    .bus_in   (bus_in),
    .cycle    (cycle),
    .sync     (sync),
    .opr      (opr),
    .opa      (opa),
    .arg_hi   (arg_hi),
    .arg_lo   (arg_lo),
    .word2    (word2),
    .fin_ind  (fin_ind),
    .pc_inc   (pc_inc),
    .exec     (exec),
    .cm_rom   (cm_rom),
    .cm_ram   (cm_ram),
    .halted   (halted)
  );

  typedef struct packed {
    logic [2:0] cyc;
    logic       sync;
    logic [3:0] opr;
    logic [3:0] opa;
    logic [3:0] ahi;
    logic [3:0] alo;
    logic       word2;
    logic       fin;
    logic       pc;
    logic       ex;
    logic       rom;
    logic       ram;
    logic       hlt;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   armed  = 1'b0;

  // Reference model: phase 0..7 = A1..X3; word 0=first, 1=second, 2=FIN indirect
  int         m_phase = 0;
  int         m_word  = 0;
  logic [3:0] m_opr = 4'h0, m_opa = 4'h0, m_ahi = 4'h0, m_alo = 4'h0;
  bit         m_halted = 1'b0;

  // Drive one clock interval, predict what the DUT shows in it, then model the edge
  task automatic tick(input bit r, input bit s, input bit h, input logic [3:0] b);
    obs_t e;
    bit   two, fin, live, ex, io;
    int   nw;
    @(posedge clk);
    #1;
    rst = r; step = s; halt_req = h; bus_in = b;

    two  = (m_opr == 4'h1) || (m_opr == 4'h4) || (m_opr == 4'h5) || (m_opr == 4'h7)
        || ((m_opr == 4'h2) && !m_opa[0]);
    fin  = (m_opr == 4'h3) && !m_opa[0];
    live = !r && !m_halted;
    ex   = live && (m_phase >= 5) && ((m_word != 0) || !(two || fin));
    io   = ex && ((m_opr == 4'hE) || ((m_opr == 4'h2) && m_opa[0]));

    e.cyc   = 3'(m_phase);
    e.sync  = live && (m_phase == 7);
    e.opr   = m_opr;
    e.opa   = m_opa;
    e.ahi   = m_ahi;
    e.alo   = m_alo;
    e.word2 = (m_word == 1);
    e.fin   = (m_word == 2);
    e.pc    = live && s && (m_phase == 4) && (m_word != 2);
    e.ex    = ex;
    e.rom   = live && ((m_phase == 2) || ((m_phase == 6) && io));
    e.ram   = live && (m_phase == 6) && io;
    e.hlt   = m_halted;
    exp_q.push_back(e);
    armed = 1'b1;

    if (r) begin
      m_phase = 0; m_word = 0; m_halted = 1'b0;
      m_opr = 4'h0; m_opa = 4'h0; m_ahi = 4'h0; m_alo = 4'h0;
    end else if (m_halted) begin
      if (!h) m_halted = 1'b0;
    end else if (s) begin
      if (m_phase == 3) begin
        if (m_word == 0) m_opr = b; else m_ahi = b;
      end
      if (m_phase == 4) begin
        if (m_word == 0) m_opa = b; else m_alo = b;
      end
      if (m_phase == 7) begin
        nw = 0;
        if (m_word == 0 && two)      nw = 1;
        else if (m_word == 0 && fin) nw = 2;
        if (nw == 0 && h) m_halted = 1'b1;
        m_word = nw;
      end
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  // One interval with the ROM presenting word w at M1/M2 and noise elsewhere
  task automatic tick_w(input logic [7:0] w, input bit s, input bit h);
    logic [3:0] b;
    b = 4'($urandom);
    if (m_phase == 3)      b = w[7:4];
    else if (m_phase == 4) b = w[3:0];
    tick(1'b0, s, h, b);
  endtask

  task automatic feed(input logic [7:0] w, input bit h);
    for (int i = 0; i < 8; i++) tick_w(w, 1'b1, h);
  endtask

  // Monitor: every interval the DUT presents a full observation to compare
  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {cycle, sync, opr, opa, arg_hi, arg_lo, word2, fin_ind,
           pc_inc, exec, cm_rom, cm_ram, halted};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL obs t=%0t act=%h exp=%h (cyc sync opr opa ahi alo w2 fin pc ex rom ram hlt)",
                 $time, a, e);
      end
    end else if (armed) begin
      checks++;
      errors++;
      $display("FAIL starved t=%0t act=empty required=entry", $time);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t act=timeout required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with step high
    repeat (3) tick(1'b1, 1'b1, 1'b0, 4'($urandom));

    feed(8'h00, 1'b0);                      // NOP: plain A1..X3 walk
    feed(8'hD5, 1'b0);                      // LDM 5
    feed(8'h42, 1'b0); feed(8'h35, 1'b0);   // JUN 0x235
    feed(8'h30, 1'b0); feed(8'h77, 1'b0);   // FIN then indirect fetch
    feed(8'h21, 1'b0);                      // SRC
    feed(8'hE0, 1'b0);                      // WRM
    feed(8'h20, 1'b0); feed(8'h9C, 1'b0);   // FIM

    // Halt requested throughout a JMS: takes effect after its second word
    feed(8'h5A, 1'b1); feed(8'hBC, 1'b1);
    repeat (3) tick_w(8'h00, 1'b1, 1'b1);
    tick_w(8'h00, 1'b1, 1'b0);
    feed(8'hD5, 1'b0);

    // Step held low mid-cycle
    repeat (3) tick_w(8'h42, 1'b1, 1'b0);
    repeat (5) tick_w(8'h42, 1'b0, 1'b0);
    repeat (5) tick_w(8'h42, 1'b1, 1'b0);
    repeat (4) tick_w(8'h35, 1'b1, 1'b0);
    repeat (5) tick_w(8'h35, 1'b0, 1'b1);
    repeat (4) tick_w(8'h35, 1'b1, 1'b0);

    // Reset in the middle of a two-word instruction
    feed(8'h14, 1'b0);
    repeat (5) tick_w(8'h66, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 4'($urandom));
    feed(8'hE4, 1'b0);

    // Randomized traffic
    repeat (3000) begin
      tick(($urandom % 250) == 0, ($urandom % 4) != 0, ($urandom % 12) == 0, 4'($urandom));
    end

    @(negedge clk);
    #1 armed = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcs4_cycle_sequencer.md
Name: mcs4_cycle_sequencer

Overview:
- Instruction-cycle controller for the MCS-4 CPU core. Steps the 8-phase subcycle (A1,A2,A3,M1,M2,X1,X2,X3), issues SYNC, and latches OPR/OPA from the 4-bit data bus.
- Classifies each fetched word as single-word, two-word (JCN/FIM/JUN/JMS/ISZ) or FIN indirect, and sequences the extra instruction cycle those need.
- Drives PC-increment, execute-window and CM-ROM/CM-RAM strobes for the datapath, and supports halting at instruction boundaries.

Parameters:
- none; all widths and encodings come from package mcs4 (Char_width=4, instr_cyc_t, opcode localparams).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- step  input  1  advance one subcycle on this clock edge; when low, all state holds
- halt_req  input  1  request to stop at the next instruction boundary
- bus_in  input  4  data bus nibble from ROM
- cycle  output  3  current subcycle (instr_cyc_t)
- sync  output  1  high while cycle==X3 and not halted
- opr  output  4  first-word high nibble (latched)
- opa  output  4  first-word low nibble (latched)
- arg_hi  output  4  second-word high nibble (latched)
- arg_lo  output  4  second-word low nibble (latched)
- word2  output  1  current instruction cycle is a two-word argument fetch
- fin_ind  output  1  current instruction cycle is a FIN indirect fetch
- pc_inc  output  1  single-clock PC increment strobe
- exec  output  1  execute window: instruction complete, X1..X3
- cm_rom  output  1  CM-ROM strobe
- cm_ram  output  1  CM-RAM strobe
- halted  output  1  sequencer stopped

Behaviour:
- Reset values: cycle=A1, word state=FIRST, opr=opa=arg_hi=arg_lo=0 (NOP), halted=0. All strobes are low while rst is high.
- Word state is one of FIRST, SECOND, FIND. word2=(state==SECOND), fin_ind=(state==FIND).
- Subcycle counter: on clk with step=1 and !halted, cycle advances A1→A2→…→X3→A1 (wraps). step=0 holds every register.
- Latching:
  - step at M1: state FIRST → opr<=bus_in; state SECOND or FIND → arg_hi<=bus_in.
  - step at M2: same rule for opa / arg_lo.
  - opr/opa are not modified during SECOND or FIND cycles.
- Two-word decode from latched opr/opa:
  - JCN (0001), JUN (0100), JMS (0101), ISZ (0111) are two-word.
  - FIM is opr 0010 with opa[0]=0.
  - FIN is opr 0011 with opa[0]=0. It is not two-word, but it needs the FIND cycle.
- Transitions on step at X3:
  - FIRST & two-word → SECOND.
  - FIRST & FIN → FIND.
  - Otherwise → FIRST.
- Halt:
  - halt_req is sampled only on step at X3 when the next state is FIRST. If high, halted<=1 and cycle<=A1.
  - While halted, step is ignored and sync, pc_inc, exec, cm_rom and cm_ram are all 0.
  - halted clears on the first clock with halt_req=0; counting resumes at A1 on the next step.
  - halt_req during FIRST of a two-word instruction or FIN is deferred until the instruction completes.
- Combinational strobes (all gated by !halted):
  - pc_inc = step & cycle==M2 & state!=FIND. The FIND fetch uses register-pair-0 addressing, so the PC is not incremented.
  - exec = cycle∈{X1,X2,X3}, and one of:
    - state FIRST & instruction is not two-word/FIN;
    - state SECOND;
    - state FIND.
  - IORAM/SRC condition: exec & (opr==IORAM_OPR or (opr==0010 & opa[0]=1)).
  - cm_rom = (cycle==A3) | (cycle==X2 & IORAM/SRC condition).
  - cm_ram = (cycle==X2 & IORAM/SRC condition).
  - sync = cycle==X3 & !halted.
- rst mid-instruction: sync reset wins over step. State returns to FIRST/A1 regardless of pending SECOND/FIND, and no strobe is asserted on the reset clock.

Test Plan:
- Reset with step=1 for 3 clocks → cycle=A1, opr=opa=0, sync=0, halted=0. Release, apply 8 steps → cycle sequence A1..X3 then A1; sync=1 exactly during X3.
- Single word LDM 5: bus M1=1101, M2=0101 → opr=D, opa=5; pc_inc=1 on M2 step; exec=1 for X1..X3; next state FIRST.
- Two-word JUN 0x4_2_35: words 0x42 then 0x35 → first cycle exec=0, word2=1 in second cycle, arg_hi=3, arg_lo=5, opr/opa stay 4/2; pc_inc pulses twice; exec only in second X1..X3.
- FIN (0x30) → fin_ind=1 in the following cycle; pc_inc=0 on that cycle's M2; arg captured; exec in FIND X-phases.
- SRC (0x21) and WRM (0xE0) → cm_rom=cm_ram=1 only at X2; cm_rom=1 at A3 every cycle.
- halt_req=1 asserted during FIRST of JMS → no halt until SECOND X3 completes; then halted=1, cycle=A1, sync=0 despite step=1; deassert → resumes at A1 on next step. Repeat with step held low for 5 clocks mid-cycle → all registers unchanged.
